// File: rtl/starfield_pkg.sv
// starfield_pkg: shared constants for the star generator.
//   - Video timing defaults (total pixels per line / lines per frame).
//   - Default LFSR length, taps and reload seed.
//   - Density mask presets: fewer zero bits in the mask means more stars.
//   - pix_t: the per-pixel result handed to the pixel mixer.
package starfield_pkg;

  localparam int H_DEF   = 800;
  localparam int V_DEF   = 525;
  localparam int INC_DEF = -1;
  localparam int LEN_DEF = 21;

  localparam logic [20:0] TAPS_DEF = 21'h140000;
  localparam logic [20:0] SEED_DEF = 21'h1FFFFF;

  // A star is lit when every bit of (sreg | mask) is 1, so each zero bit in
  // the mask halves the expected density.
  localparam logic [20:0] MASK_LOW  = 21'h0003FF;
  localparam logic [20:0] MASK_MED  = 21'h0007FF;
  localparam logic [20:0] MASK_HIGH = 21'h000FFF;

  typedef enum logic [1:0] {
    DENS_LOW  = 2'd0,
    DENS_MED  = 2'd1,
    DENS_HIGH = 2'd2
  } density_e;

  typedef struct packed {
    logic       star_on;
    logic [7:0] brightness;
  } pix_t;

  // Mask for a given density preset.
  function automatic logic [20:0] density_mask(density_e d);
    logic [20:0] m;
    m = MASK_MED;
    case (d)
      DENS_LOW:  m = MASK_LOW;
      DENS_MED:  m = MASK_MED;
      DENS_HIGH: m = MASK_HIGH;
      default:   m = MASK_MED;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/starfield_lfsr.sv
// lfsr: Galois LFSR, shifting right. When the bit shifted out is 1 the taps
// are XORed into the shifted value.
// Ports:
//   clk   system clock
//   rst   synchronous active-high load of seed (also used as a reload)
//   en    advance one step
//   seed  value loaded on rst
//   q     current state
module lfsr #(
  parameter int             LEN  = 21,
  parameter logic [LEN-1:0] TAPS = 21'h140000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [LEN-1:0] seed,
  output logic [LEN-1:0] q
);

  logic [LEN-1:0] q_next;

  always_comb begin
    q_next = q >> 1;
    if (q[0]) q_next = (q >> 1) ^ TAPS;
  end

  always_ff @(posedge clk) begin
    if (rst)     q <= seed;
    else if (en) q <= q_next;
  end

endmodule

// File: rtl/starfield.sv
// starfield: pixel-rate star generator.
// Walks an LFSR one step per pixel strobe and reloads the seed every
// P = H*V + INC pixels. Because P differs from the frame length by INC, the
// star pattern drifts INC pixels per frame (negative scrolls left).
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   en          pixel strobe: advance one pixel this cycle
//   frame_sync  single-cycle pulse: restart the period at pixel 0 / SEED
//   star_on     registered: current pixel is a star
//   brightness  registered: sreg[7:0] for a star, else 0
//   pix_valid   registered: star_on/brightness carry a new pixel this cycle
//   sreg        current LFSR state
//
// Pixel handshake: each cycle with en=1 (and no rst/frame_sync) consumes one
// pixel, computed from sreg as it was before that edge; the result appears one
// cycle later with pix_valid=1. There is no backpressure. When no pixel was
// consumed, pix_valid is 0 and star_on/brightness keep their last values.
module starfield
  import starfield_pkg::*;
#(
  parameter int             H    = H_DEF,
  parameter int             V    = V_DEF,
  parameter int             INC  = INC_DEF,
  parameter int             LEN  = LEN_DEF,
  parameter logic [LEN-1:0] TAPS = TAPS_DEF,
  parameter logic [LEN-1:0] SEED = SEED_DEF,
  parameter logic [LEN-1:0] MASK = MASK_MED,
  parameter int             CW   = $clog2(H*V+1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           frame_sync,
  output logic           star_on,
  output logic [7:0]     brightness,
  output logic           pix_valid,
  output logic [LEN-1:0] sreg
);

  // Reload period; P-1 must fit in CW bits (holds for INC <= 1).
  localparam int          P      = H*V + INC;
  localparam logic [CW-1:0] P_LAST = CW'(P - 1);

  logic [CW-1:0] cnt;
  logic          wrap;
  logic          lfsr_en;
  logic          lfsr_rst;
  pix_t          pix_next;

  assign wrap = (cnt == P_LAST);

  // On the wrap pixel the LFSR reloads instead of stepping, so the sequence
  // restarts from SEED exactly every P strobes.
  assign lfsr_en  = en & ~frame_sync & ~wrap;
  assign lfsr_rst = rst | frame_sync | (en & wrap);

  lfsr #(
    .LEN  (LEN),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk  (clk),
    .rst  (lfsr_rst),
    .en   (lfsr_en),
    .seed (SEED),
    .q    (sreg)
  );

  always_comb begin
    pix_next.star_on    = &(sreg | MASK);
    pix_next.brightness = pix_next.star_on ? sreg[7:0] : 8'h00;
  end

  // Pixel counter within the reload period.
  always_ff @(posedge clk) begin
    if (rst || frame_sync) begin
      cnt <= '0;
    end else if (en) begin
      if (wrap) cnt <= '0;
      else      cnt <= cnt + CW'(1);
    end
  end

  // Output stage: one cycle of latency; values hold while no pixel is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      star_on    <= 1'b0;
      brightness <= 8'h00;
      pix_valid  <= 1'b0;
    end else if (frame_sync) begin
      pix_valid  <= 1'b0;
    end else if (en) begin
      star_on    <= pix_next.star_on;
      brightness <= pix_next.brightness;
      pix_valid  <= 1'b1;
    end else begin
      pix_valid  <= 1'b0;
    end
  end

endmodule
